// File: rtl/controller_data_ram_mover.sv
// Avalon-MM block mover for the controller's dual-port data RAM.
// Copies a word range in place with memmove ordering and address wrap-around.
module controller_data_ram_mover #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  cmd_abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   words_done,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [3:0]            m_byteenable,
    output logic [DATA_WIDTH-1:0] m_writedata,
    output logic                  m_clken,
    input  logic [DATA_WIDTH-1:0] m_readdata
);

    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FINISH
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  descending;

    logic [ADDR_WIDTH-1:0] fwd_dist;
    logic [ADDR_WIDTH-1:0] len_m1;
    logic                  start_desc;
    logic [ADDR_WIDTH-1:0] rd_start;
    logic [ADDR_WIDTH-1:0] wr_start;
    logic [ADDR_WIDTH-1:0] rd_step;
    logic [ADDR_WIDTH-1:0] wr_step;
    logic [LEN_WIDTH-1:0]  words_next;

    // Descend when the destination starts inside the source window, so no
    // source word is overwritten before it has been read.
    assign fwd_dist   = cmd_dst - cmd_src;
    assign start_desc = (LEN_WIDTH'(fwd_dist) < cmd_len) && (cmd_dst != cmd_src);
    assign len_m1     = ADDR_WIDTH'(cmd_len - LEN_WIDTH'(1));
    assign rd_start   = start_desc ? cmd_src + len_m1 : cmd_src;
    assign wr_start   = start_desc ? cmd_dst + len_m1 : cmd_dst;

    assign rd_step    = descending ? rd_ptr - ADDR_WIDTH'(1) : rd_ptr + ADDR_WIDTH'(1);
    assign wr_step    = descending ? wr_ptr - ADDR_WIDTH'(1) : wr_ptr + ADDR_WIDTH'(1);
    assign words_next = words_done + LEN_WIDTH'(1);

    // Read data flows straight to the write port in the cycle after its read.
    assign m_writedata  = (state == WRITE) ? m_readdata : '0;
    assign m_byteenable = {4{m_chipselect}};
    assign m_clken      = 1'b1;

    // Sequencer; bus strobes and address are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            len_q        <= '0;
            descending   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            words_done   <= '0;
            m_address    <= '0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        len_q      <= cmd_len;
                        descending <= start_desc;
                        rd_ptr     <= rd_start;
                        wr_ptr     <= wr_start;
                        words_done <= '0;
                        aborted    <= 1'b0;
                        busy       <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state        <= READ;
                            m_chipselect <= 1'b1;
                            m_write      <= 1'b0;
                            m_address    <= rd_start;
                        end
                    end
                end
                READ: begin
                    if (cmd_abort) begin
                        state        <= FINISH;
                        aborted      <= 1'b1;
                        done         <= 1'b1;
                        m_chipselect <= 1'b0;
                        m_write      <= 1'b0;
                        m_address    <= '0;
                    end else begin
                        state     <= WRITE;
                        m_write   <= 1'b1;
                        m_address <= wr_ptr;
                    end
                end
                WRITE: begin
                    words_done <= words_next;
                    rd_ptr     <= rd_step;
                    wr_ptr     <= wr_step;
                    if (cmd_abort || (words_next == len_q)) begin
                        state        <= FINISH;
                        aborted      <= cmd_abort;
                        done         <= 1'b1;
                        m_chipselect <= 1'b0;
                        m_write      <= 1'b0;
                        m_address    <= '0;
                    end else begin
                        state     <= READ;
                        m_write   <= 1'b0;
                        m_address <= rd_step;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_data_ram_mover.sv
// Randomized bench for controller_data_ram_mover with a RAM model and a
// per-cycle expectation queue built from the copy rules.
module tb_controller_data_ram_mover;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 13;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_start;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [LW-1:0] cmd_len;
    logic          cmd_abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] words_done;
    logic [AW-1:0] m_address;
    logic          m_chipselect;
    logic          m_write;
    logic [3:0]    m_byteenable;
    logic [DW-1:0] m_writedata;
    logic          m_clken;
    logic [DW-1:0] m_readdata;

    always #5 clk = ~clk;

    controller_data_ram_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_src(cmd_src),
        .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_clken(m_clken),
        .m_readdata(m_readdata)
    );

    // RAM: registered read address, unregistered read data
    logic [DW-1:0] ram    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    logic [AW-1:0] rd_q;
    logic          load_req = 1'b0;
    logic          poke_en  = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= shadow[i];
        end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (m_chipselect && m_write) begin
            ram[m_address] <= m_writedata;
        end
        if (m_chipselect && !m_write) rd_q <= m_address;
    end
    assign m_readdata = ram[rd_q];

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          cs;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [LW-1:0] wd;
        logic          ab;
    } exp_t;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    bit            chk_en   = 1'b0;
    logic [LW-1:0] last_wd  = '0;
    logic          last_ab  = 1'b0;
    int            done_cyc;
    int            first_wa;
    bit            cs_seen;

    function automatic exp_t mk(logic b, logic d, logic cs, logic wr, logic [AW-1:0] a,
                                logic [DW-1:0] wdat, logic [LW-1:0] wd, logic ab);
        exp_t e;
        e.busy = b; e.done = d; e.cs = cs; e.wr = wr;
        e.addr = a; e.wdata = wdat; e.wd = wd; e.ab = ab;
        return e;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    // Per-cycle comparison against the planned expectation (idle when empty)
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, last_wd, last_ab);
            chk("busy", 64'(busy), 64'(e.busy));
            chk("done", 64'(done), 64'(e.done));
            chk("chipselect", 64'(m_chipselect), 64'(e.cs));
            chk("write", 64'(m_write), 64'(e.wr));
            chk("byteenable", 64'(m_byteenable), e.cs ? 64'hF : 64'h0);
            chk("clken", 64'(m_clken), 64'd1);
            chk("words_done", 64'(words_done), 64'(e.wd));
            chk("aborted", 64'(aborted), 64'(e.ab));
            if (e.cs) chk("address", 64'(m_address), 64'(e.addr));
            if (e.wr || !e.busy) chk("writedata", 64'(m_writedata), 64'(e.wdata));
        end
    end

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1; shadow[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Issue one command; abort_c/rst_c/bs_c are cycle numbers (0 = none)
    task automatic run_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [LW-1:0] len, input int abort_c,
                           input int rst_c, input int bs_c);
        logic [AW-1:0] diff, ra, wa;
        logic [DW-1:0] data;
        logic [LW-1:0] wd;
        logic          desc, ab;
        bit            rst_hit;
        int            c, k, n;
        cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        diff = dst - src;
        desc = ({1'b0, diff} < len) && (dst != src);
        wd = '0; ab = 1'b0; rst_hit = 1'b0; c = 1; k = 0;
        if (len != '0) begin
            while (1) begin
                ra = desc ? AW'(int'(src) + int'(len) - 1 - k) : AW'(int'(src) + k);
                wa = desc ? AW'(int'(dst) + int'(len) - 1 - k) : AW'(int'(dst) + k);
                exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, ra, '0, wd, 1'b0));
                if (c == rst_c) begin rst_hit = 1'b1; break; end
                if (c == abort_c) begin ab = 1'b1; break; end
                c++;
                data = shadow[ra];
                exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, wa, data, wd, 1'b0));
                shadow[wa] = data;
                wd = wd + LW'(1);
                if (c == rst_c) begin rst_hit = 1'b1; break; end
                if (c == abort_c) ab = 1'b1;
                c++;
                if (ab || wd == len) break;
                k++;
            end
        end
        if (!rst_hit) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, wd, ab));
        last_wd = rst_hit ? '0 : wd;
        last_ab = rst_hit ? 1'b0 : ab;
        n = exp_q.size();
        done_cyc = -1; first_wa = -1; cs_seen = 1'b0;
        for (int cc = 1; cc <= n; cc++) begin
            if (done && done_cyc < 0) done_cyc = cc;
            if (m_chipselect) cs_seen = 1'b1;
            if (m_chipselect && m_write && first_wa < 0) first_wa = int'(m_address);
            cmd_abort = (cc == abort_c);
            reset     = (cc == rst_c);
            if (cc == bs_c) begin
                cmd_start = 1'b1;
                cmd_src   = AW'($urandom);
                cmd_dst   = AW'($urandom);
                cmd_len   = LW'($urandom_range(1, 50));
            end else begin
                cmd_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        cmd_abort = 1'b0; reset = 1'b0; cmd_start = 1'b0;
    endtask

    initial begin
        int len, ab_c, bs_c, mism;
        logic [AW-1:0] s, d;
        reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
        cmd_src = '0; cmd_dst = '0; cmd_len = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = $urandom;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_aborted", 64'(aborted), 64'd0);
        chk("rst_words_done", 64'(words_done), 64'd0);
        chk("rst_address", 64'(m_address), 64'd0);
        chk("rst_chipselect", 64'(m_chipselect), 64'd0);
        chk("rst_write", 64'(m_write), 64'd0);
        chk("rst_byteenable", 64'(m_byteenable), 64'd0);
        chk("rst_writedata", 64'(m_writedata), 64'd0);
        chk("rst_clken", 64'(m_clken), 64'd1);
        reset = 1'b0;
        chk_en = 1'b1;

        // plain copy
        poke(0, 32'hAAAA_0001); poke(1, 32'hBBBB_0002);
        poke(2, 32'hCCCC_0003); poke(3, 32'hDDDD_0004);
        run_cmd(0, 10, 4, 0, 0, 0);
        chk("t1_done_cycle", 64'(done_cyc), 64'd9);
        chk("t1_ram10", 64'(ram[10]), 64'hAAAA_0001);
        chk("t1_ram13", 64'(ram[13]), 64'hDDDD_0004);
        chk("t1_words_done", 64'(words_done), 64'd4);
        chk("t1_aborted", 64'(aborted), 64'd0);

        // forward overlap -> descending
        for (int i = 0; i < 5; i++) poke(AW'(i), DW'(i + 1));
        run_cmd(0, 2, 5, 0, 0, 0);
        chk("t2_first_write", 64'(first_wa), 64'd6);
        for (int i = 0; i < 5; i++) chk("t2_ram", 64'(ram[2 + i]), 64'(i + 1));

        // wrap-around on source and destination
        poke(4094, 32'h1111_4094); poke(4095, 32'h2222_4095);
        poke(0, 32'h3333_0000); poke(1, 32'h4444_0001);
        run_cmd(4094, 100, 4, 0, 0, 0);
        chk("t3_ram100", 64'(ram[100]), 64'h1111_4094);
        chk("t3_ram102", 64'(ram[102]), 64'h3333_0000);
        chk("t3_ram103", 64'(ram[103]), 64'h4444_0001);
        run_cmd(100, 4095, 2, 0, 0, 0);
        chk("t3_first_write", 64'(first_wa), 64'd4095);
        chk("t3_ram4095", 64'(ram[4095]), 64'h1111_4094);
        chk("t3_ram0", 64'(ram[0]), 64'h2222_4095);

        // zero length, then back-to-back start with an ignored busy start
        run_cmd(7, 9, 0, 0, 0, 0);
        chk("t4_done_cycle", 64'(done_cyc), 64'd1);
        chk("t4_no_access", 64'(cs_seen), 64'd0);
        run_cmd(300, 700, 6, 0, 0, 3);
        chk("t4_words_done", 64'(words_done), 64'd6);

        // aborts in READ and WRITE
        run_cmd(200, 300, 8, 5, 0, 0);
        chk("t5_words_done", 64'(words_done), 64'd2);
        chk("t5_aborted", 64'(aborted), 64'd1);
        chk("t5_done_cycle", 64'(done_cyc), 64'd6);
        run_cmd(200, 300, 8, 6, 0, 0);
        chk("t5b_words_done", 64'(words_done), 64'd3);
        chk("t5b_done_cycle", 64'(done_cyc), 64'd7);

        // reset mid-copy, then a clean command
        run_cmd(500, 600, 8, 0, 5, 0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_chipselect", 64'(m_chipselect), 64'd0);
        run_cmd(500, 600, 8, 0, 0, 0);
        chk("t6_ram607", 64'(ram[607]), 64'(shadow[607]));

        // randomized commands
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                cmd_abort = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            cmd_abort = 1'b0;
            len = (t == 20) ? 4096 : int'($urandom_range(0, 40));
            s = AW'($urandom);
            d = ($urandom_range(0, 1) == 1) ? AW'(int'(s) + int'($urandom_range(0, 50)) - 25)
                                            : AW'($urandom);
            ab_c = ($urandom_range(0, 3) == 0 && len > 0) ? int'($urandom_range(1, 2 * len + 1)) : 0;
            bs_c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * len + 1)) : 0;
            run_cmd(s, d, LW'(len), ab_c, 0, bs_c);
        end

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== shadow[i]) mism++;
        chk("ram_image", 64'(mism), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
